// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle distance between consecutive rising edges of pulse_in,
// reporting it with a one-cycle valid pulse and flagging overdue edges as timeouts.
module pulse_period_meter #(
   parameter int WIDTH = 28
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pulse_in,
   input  logic [WIDTH-1:0] timeout,
   output logic [WIDTH-1:0] period,
   output logic             period_valid,
   output logic             timed_out,
   output logic             busy
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   state_t           state;
   state_t           state_next;
   logic             prev;
   logic             rise;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] period_next;
   logic             valid_next;
   logic             timed_out_next;

   assign rise = pulse_in & ~prev;

   // prev follows pulse_in even while disabled, so edges inside a disabled window are lost
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         prev         <= 1'b0;
         count        <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timed_out    <= 1'b0;
      end else begin
         prev         <= pulse_in;
         state        <= state_next;
         count        <= count_next;
         period       <= period_next;
         period_valid <= valid_next;
         timed_out    <= timed_out_next;
      end
   end

   // A closing rise takes priority over the timeout and immediately opens the next interval
   always_comb begin
      state_next     = state;
      count_next     = count;
      period_next    = period;
      valid_next     = 1'b0;
      timed_out_next = 1'b0;
      if (enable) begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_next = MEASURE;
                  count_next = ONE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_next = count;
                  valid_next  = 1'b1;
                  count_next  = ONE;
               end else if ((timeout != '0) && (count >= timeout)) begin
                  timed_out_next = 1'b1;
                  count_next     = '0;
                  state_next     = IDLE;
               end else if (count != ALL_ONES) begin
                  count_next = count + ONE;
               end
            end
            default: begin
               state_next = IDLE;
               count_next = '0;
            end
         endcase
      end
   end

   always_comb begin
      busy = (state == MEASURE);
   end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: directed scenarios plus random traffic,
// all compared against a timestamp-based reference model.
module tb_pulse_period_meter;

   localparam int W  = 28;
   localparam int W4 = 4;

   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic          enable   = 1'b0;
   logic          pulse_in = 1'b0;
   logic [W-1:0]  timeout  = '0;
   logic [W-1:0]  period;
   logic          period_valid;
   logic          timed_out;
   logic          busy;

   logic          enable4   = 1'b0;
   logic          pulse_in4 = 1'b0;
   logic [W4-1:0] timeout4  = '0;
   logic [W4-1:0] period4;
   logic          period_valid4;
   logic          timed_out4;
   logic          busy4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pulse_period_meter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
      .timeout(timeout), .period(period), .period_valid(period_valid),
      .timed_out(timed_out), .busy(busy)
   );

   pulse_period_meter #(.WIDTH(W4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable4), .pulse_in(pulse_in4),
      .timeout(timeout4), .period(period4), .period_valid(period_valid4),
      .timed_out(timed_out4), .busy(busy4)
   );

   // Model: stamp each enabled edge; an interval is the stamp difference of two rises
   longint m_ecyc[2], m_topen[2], m_period[2];
   bit     m_open[2], m_valid[2], m_to[2], m_prev[2];

   task automatic model_step(input int i, input bit p, input bit en, input longint tmo,
                             input longint maxv);
      bit     r;
      longint el;
      r          = p && !m_prev[i];
      m_prev[i]  = p;
      m_valid[i] = 1'b0;
      m_to[i]    = 1'b0;
      if (en) begin
         m_ecyc[i]++;
         if (!m_open[i]) begin
            if (r) begin
               m_open[i]  = 1'b1;
               m_topen[i] = m_ecyc[i];
            end
         end else begin
            el = m_ecyc[i] - m_topen[i];
            if (el > maxv) el = maxv;
            if (r) begin
               m_period[i] = el;
               m_valid[i]  = 1'b1;
               m_topen[i]  = m_ecyc[i];
            end else if (tmo != 0 && el >= tmo) begin
               m_to[i]   = 1'b1;
               m_open[i] = 1'b0;
            end
         end
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            m_ecyc[i] = 0; m_topen[i] = 0; m_period[i] = 0;
            m_open[i] = 0; m_valid[i] = 0; m_to[i] = 0; m_prev[i] = 0;
         end
      end else begin
         model_step(0, pulse_in, enable, longint'(timeout), (longint'(1) << W) - 1);
         model_step(1, pulse_in4, enable4, longint'(timeout4), (longint'(1) << W4) - 1);
      end
   end

   function automatic logic [W+2:0] obs0();
      return {period, period_valid, timed_out, busy};
   endfunction
   function automatic logic [W+2:0] exp0();
      return {m_period[0][W-1:0], m_valid[0], m_to[0], m_open[0]};
   endfunction
   function automatic logic [W4+2:0] obs4();
      return {period4, period_valid4, timed_out4, busy4};
   endfunction
   function automatic logic [W4+2:0] exp4();
      return {m_period[1][W4-1:0], m_valid[1], m_to[1], m_open[1]};
   endfunction

   task automatic tick(input logic p, input logic en);
      pulse_in = p;
      enable   = en;
      @(posedge clk);
      #1;
   endtask

   task automatic tick4(input logic p, input logic en);
      pulse_in4 = p;
      enable4   = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pulse_in = 1'b0;
      reset    = 1'b0;
      #2;
      reset    = 1'b1;
   endtask

   task automatic test_reset();
      timeout = W'(100);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs0() !== '0 || obs4() !== '0) begin
         errors++;
         $display("FAIL reset_initial: got %h/%h exp 0/0", obs0(), obs4());
      end
      reset = 1'b1;
      tick(1'b1, 1'b1);
      for (int k = 0; k < 7; k++) begin
         tick(1'b0, 1'b1);
         checks++;
         if (obs0() !== exp0()) begin
            errors++;
            $display("FAIL reset_run: got %h exp %h", obs0(), exp0());
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_busy_before: got %b exp 1", busy);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs0() !== '0 || obs0() !== exp0()) begin
         errors++;
         $display("FAIL reset_async: got %h exp 0", obs0());
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(1'b1, 1'b1);
      checks++;
      if (period_valid !== 1'b0 || busy !== 1'b1 || obs0() !== exp0()) begin
         errors++;
         $display("FAIL reset_first_rise: got %h exp %h", obs0(), exp0());
      end
      repeat (5) tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      checks++;
      if (period_valid !== 1'b1 || period !== W'(6) || obs0() !== exp0()) begin
         errors++;
         $display("FAIL reset_fresh_period: got %h exp %h (period 6)", obs0(), exp0());
      end
   endtask

   task automatic test_periodic();
      int stray;
      stray = 0;
      do_reset();
      timeout = W'(100);
      for (int r = 0; r < 5; r++) begin
         tick(1'b1, 1'b1);
         checks++;
         if (r == 0) begin
            if (period_valid !== 1'b0 || busy !== 1'b1 || obs0() !== exp0()) begin
               errors++;
               $display("FAIL periodic_open: got %h exp %h", obs0(), exp0());
            end
         end else if (period_valid !== 1'b1 || period !== W'(10) || obs0() !== exp0()) begin
            errors++;
            $display("FAIL periodic_valid%0d: got %h exp %h (period 10)", r, obs0(), exp0());
         end
         for (int k = 0; k < 9; k++) begin
            tick(1'b0, 1'b1);
            if (period_valid !== 1'b0) stray++;
         end
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL periodic_width: got %0d extra valid cycles exp 0", stray);
      end
   endtask

   task automatic test_timeout();
      int to_at, to_cnt, v_cnt;
      to_at = -1; to_cnt = 0; v_cnt = 0;
      timeout = W'(20);
      tick(1'b1, 1'b1);
      for (int k = 1; k <= 25; k++) begin
         tick(1'b0, 1'b1);
         checks++;
         if (obs0() !== exp0()) begin
            errors++;
            $display("FAIL timeout_cycle%0d: got %h exp %h", k, obs0(), exp0());
         end
         if (timed_out === 1'b1) begin
            to_cnt++;
            if (to_at < 0) to_at = k;
         end
         if (period_valid === 1'b1) v_cnt++;
      end
      checks++;
      if (to_at != 20 || to_cnt != 1 || v_cnt != 0 || period !== W'(10) || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_summary: got at=%0d n=%0d valids=%0d period=%0d busy=%b exp 20 1 0 10 0",
                  to_at, to_cnt, v_cnt, period, busy);
      end
   endtask

   task automatic test_boundary();
      int to_cnt, v_cnt;
      to_cnt = 0; v_cnt = 0;
      do_reset();
      timeout = W'(15);
      tick(1'b1, 1'b1);
      for (int k = 0; k < 14; k++) begin
         tick(1'b0, 1'b1);
         if (timed_out === 1'b1) to_cnt++;
      end
      tick(1'b1, 1'b1);
      checks++;
      if (period_valid !== 1'b1 || period !== W'(15) || timed_out !== 1'b0 || to_cnt != 0
          || obs0() !== exp0()) begin
         errors++;
         $display("FAIL boundary_15: got %h to=%0d exp %h (period 15, no timeout)",
                  obs0(), to_cnt, exp0());
      end
      for (int k = 1; k <= 15; k++) begin
         tick(1'b0, 1'b1);
         if (timed_out === 1'b1) to_cnt++;
         if (period_valid === 1'b1) v_cnt++;
      end
      tick(1'b1, 1'b1);
      checks++;
      if (to_cnt != 1 || v_cnt != 0 || period_valid !== 1'b0 || busy !== 1'b1
          || obs0() !== exp0()) begin
         errors++;
         $display("FAIL boundary_16: got to=%0d valids=%0d %h exp 1 0 %h", to_cnt, v_cnt,
                  obs0(), exp0());
      end
   endtask

   task automatic test_enable_gap();
      do_reset();
      timeout = W'(100);
      tick(1'b1, 1'b1);
      for (int k = 1; k <= 11; k++) begin
         tick(logic'(k == 6), logic'(!(k >= 4 && k <= 8)));
         checks++;
         if (obs0() !== exp0()) begin
            errors++;
            $display("FAIL gap_cycle%0d: got %h exp %h", k, obs0(), exp0());
         end
      end
      tick(1'b1, 1'b1);
      checks++;
      if (period_valid !== 1'b1 || period !== W'(7) || obs0() !== exp0()) begin
         errors++;
         $display("FAIL gap_period: got %h exp %h (period 7)", obs0(), exp0());
      end
      enable = 1'b0;
   endtask

   task automatic test_saturation();
      int to_cnt;
      to_cnt = 0;
      timeout4 = '0;
      tick4(1'b1, 1'b1);
      for (int k = 0; k < 30; k++) begin
         tick4(1'b0, 1'b1);
         if (timed_out4 === 1'b1) to_cnt++;
         checks++;
         if (obs4() !== exp4()) begin
            errors++;
            $display("FAIL sat_cycle%0d: got %h exp %h", k, obs4(), exp4());
         end
      end
      tick4(1'b1, 1'b1);
      checks++;
      if (to_cnt != 0 || period_valid4 !== 1'b1 || period4 !== 4'hF || obs4() !== exp4()) begin
         errors++;
         $display("FAIL sat_period: got %h to=%0d exp %h (period 15)", obs4(), to_cnt, exp4());
      end
      enable4 = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      timeout = W'(25);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 3)
            timeout = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(3, 40));
         tick(logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 9) != 0));
         checks++;
         if (obs0() !== exp0() || (period_valid === 1'b1 && timed_out === 1'b1)) begin
            errors++;
            $display("FAIL random_c%0d: got %h exp %h", c, obs0(), exp0());
         end
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_timeout();
      test_boundary();
      test_enable_gap();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
